coarse_cfo_cmul_pipe: RTL and testbench

Pipelined, parametrised complex multiplier with an optional conjugate mode and an optional multiply-accumulate mode, for the coarse CFO datapath. It computes a·b or a·conj(b), optionally sums products over a window, then rounds, shifts and saturates the result to the output width. A valid/ready handshake on both sides makes it stall-safe inside HLS-generated dataflow. It replaces chains of scalar signed multipliers in the autocorrelation (x[n]·conj(x[n+16])) and phase-rotation paths.

---
 rtl/coarse_cfo_cmul_pipe_if.sv | 33 +++
 rtl/coarse_cfo_cmul_pipe.sv | 199 +++++++++++++++++++
 tb/tb_coarse_cfo_cmul_pipe.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coarse_cfo_cmul_pipe_if.sv
// Handshake and data bundle for the coarse CFO complex multiplier.
// The master side feeds operands and accepts results; the slave side is the pipeline.
interface coarse_cfo_cmul_pipe_if #(
    parameter int unsigned DIN_W  = 16,
    parameter int unsigned DOUT_W = 16
);
    // Input beat
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DIN_W-1:0]  a_re;
    logic signed [DIN_W-1:0]  a_im;
    logic signed [DIN_W-1:0]  b_re;
    logic signed [DIN_W-1:0]  b_im;
    logic                     conj_b;
    logic                     in_last;

    // Result
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DOUT_W-1:0] y_re;
    logic signed [DOUT_W-1:0] y_im;
    logic                     out_sat;

    modport master (
        output in_valid, a_re, a_im, b_re, b_im, conj_b, in_last, out_ready,
        input  in_ready, out_valid, y_re, y_im, out_sat
    );

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im, conj_b, in_last, out_ready,
        output in_ready, out_valid, y_re, y_im, out_sat
    );
endinterface

// File: rtl/coarse_cfo_cmul_pipe.sv
// Three-stage complex multiplier (a*b or a*conj(b)) with optional windowed accumulation,
// round-half-up, arithmetic shift and saturation. One global enable stalls every stage
// together, so the valid/ready handshake never drops or duplicates a beat.
module coarse_cfo_cmul_pipe #(
    parameter int unsigned DIN_W    = 16,
    parameter int unsigned DOUT_W   = 16,
    parameter int unsigned SHIFT    = 15,
    parameter int unsigned ACCUM    = 0,
    parameter int unsigned ACC_GROW = 6
) (
    input logic                   ap_clk,
    input logic                   ap_rst,
    coarse_cfo_cmul_pipe_if.slave bus
);
    localparam int unsigned PROD_W = 2 * DIN_W;
    localparam int unsigned SUM_W  = PROD_W + 1;
    localparam int unsigned ACC_W  = SUM_W + ACC_GROW;
    // One extra bit so the rounding bias can never wrap the accumulated value.
    localparam int unsigned RND_W  = ACC_W + 1;

    localparam logic signed [RND_W-1:0] RND_BIAS =
        (SHIFT > 0) ? (RND_W'(1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;
    localparam logic signed [RND_W-1:0] Y_MAX =
        {{(RND_W - DOUT_W + 1){1'b0}}, {(DOUT_W - 1){1'b1}}};
    localparam logic signed [RND_W-1:0] Y_MIN =
        {{(RND_W - DOUT_W + 1){1'b1}}, {(DOUT_W - 1){1'b0}}};

    // Global enable
    logic ce;

    // Stage 1: registered operands
    logic                    s1_valid_q;
    logic signed [DIN_W-1:0] s1_a_re_q;
    logic signed [DIN_W-1:0] s1_a_im_q;
    logic signed [DIN_W-1:0] s1_b_re_q;
    logic signed [DIN_W-1:0] s1_b_im_q;
    logic                    s1_conj_q;
    logic                    s1_last_q;

    // Stage 2: registered partial products
    logic                     s2_valid_q;
    logic signed [PROD_W-1:0] s2_rr_q;
    logic signed [PROD_W-1:0] s2_ii_q;
    logic signed [PROD_W-1:0] s2_ri_q;
    logic signed [PROD_W-1:0] s2_ir_q;
    logic                     s2_conj_q;
    logic                     s2_last_q;

    // Stage 3: combine, accumulate, convert
    logic signed [SUM_W-1:0]  sum_re;
    logic signed [SUM_W-1:0]  sum_im;
    logic signed [ACC_W-1:0]  base_re;
    logic signed [ACC_W-1:0]  base_im;
    logic signed [ACC_W-1:0]  val_re;
    logic signed [ACC_W-1:0]  val_im;
    logic signed [RND_W-1:0]  rnd_re;
    logic signed [RND_W-1:0]  rnd_im;
    logic signed [DOUT_W-1:0] y_re_d;
    logic signed [DOUT_W-1:0] y_im_d;
    logic                     sat_re;
    logic                     sat_im;

    // Accumulator state and output registers
    logic signed [ACC_W-1:0]  acc_re_q;
    logic signed [ACC_W-1:0]  acc_im_q;
    logic                     first_q;
    logic                     out_valid_q;
    logic signed [DOUT_W-1:0] y_re_q;
    logic signed [DOUT_W-1:0] y_im_q;
    logic                     out_sat_q;

    assign ce            = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = ce;
    assign bus.out_valid = out_valid_q;
    assign bus.y_re      = y_re_q;
    assign bus.y_im      = y_im_q;
    assign bus.out_sat   = out_sat_q;

    // Stage 1: capture the incoming beat (bubbles advance with valid low)
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_valid_q <= 1'b0;
            s1_a_re_q  <= '0;
            s1_a_im_q  <= '0;
            s1_b_re_q  <= '0;
            s1_b_im_q  <= '0;
            s1_conj_q  <= 1'b0;
            s1_last_q  <= 1'b0;
        end else if (ce) begin
            s1_valid_q <= bus.in_valid;
            s1_a_re_q  <= bus.a_re;
            s1_a_im_q  <= bus.a_im;
            s1_b_re_q  <= bus.b_re;
            s1_b_im_q  <= bus.b_im;
            s1_conj_q  <= bus.conj_b;
            s1_last_q  <= bus.in_last;
        end
    end

    // Stage 2: the four signed partial products
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s2_valid_q <= 1'b0;
            s2_rr_q    <= '0;
            s2_ii_q    <= '0;
            s2_ri_q    <= '0;
            s2_ir_q    <= '0;
            s2_conj_q  <= 1'b0;
            s2_last_q  <= 1'b0;
        end else if (ce) begin
            s2_valid_q <= s1_valid_q;
            s2_rr_q    <= PROD_W'(s1_a_re_q) * PROD_W'(s1_b_re_q);
            s2_ii_q    <= PROD_W'(s1_a_im_q) * PROD_W'(s1_b_im_q);
            s2_ri_q    <= PROD_W'(s1_a_re_q) * PROD_W'(s1_b_im_q);
            s2_ir_q    <= PROD_W'(s1_a_im_q) * PROD_W'(s1_b_re_q);
            s2_conj_q  <= s1_conj_q;
            s2_last_q  <= s1_last_q;
        end
    end

    // Stage 3 datapath: combine products, add accumulator, round/shift and clip
    always_comb begin
        if (s2_conj_q) begin
            sum_re = SUM_W'(s2_rr_q) + SUM_W'(s2_ii_q);
            sum_im = SUM_W'(s2_ir_q) - SUM_W'(s2_ri_q);
        end else begin
            sum_re = SUM_W'(s2_rr_q) - SUM_W'(s2_ii_q);
            sum_im = SUM_W'(s2_ri_q) + SUM_W'(s2_ir_q);
        end

        // First beat of a window starts from zero instead of the stale sum.
        base_re = '0;
        base_im = '0;
        if (ACCUM != 0 && !first_q) begin
            base_re = acc_re_q;
            base_im = acc_im_q;
        end
        val_re = base_re + ACC_W'(sum_re);
        val_im = base_im + ACC_W'(sum_im);

        rnd_re = (RND_W'(val_re) + RND_BIAS) >>> SHIFT;
        rnd_im = (RND_W'(val_im) + RND_BIAS) >>> SHIFT;

        y_re_d = rnd_re[DOUT_W-1:0];
        sat_re = 1'b0;
        if (rnd_re > Y_MAX) begin
            y_re_d = Y_MAX[DOUT_W-1:0];
            sat_re = 1'b1;
        end else if (rnd_re < Y_MIN) begin
            y_re_d = Y_MIN[DOUT_W-1:0];
            sat_re = 1'b1;
        end

        y_im_d = rnd_im[DOUT_W-1:0];
        sat_im = 1'b0;
        if (rnd_im > Y_MAX) begin
            y_im_d = Y_MAX[DOUT_W-1:0];
            sat_im = 1'b1;
        end else if (rnd_im < Y_MIN) begin
            y_im_d = Y_MIN[DOUT_W-1:0];
            sat_im = 1'b1;
        end
    end

    // Stage 3 state: accumulator, window flag and output registers
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            y_re_q      <= '0;
            y_im_q      <= '0;
            out_sat_q   <= 1'b0;
        end else if (ce) begin
            if (ACCUM == 0) begin
                out_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    y_re_q    <= y_re_d;
                    y_im_q    <= y_im_d;
                    out_sat_q <= sat_re || sat_im;
                end
            end else begin
                // Only the closing beat of a window produces a result.
                out_valid_q <= s2_valid_q && s2_last_q;
                if (s2_valid_q) begin
                    acc_re_q <= val_re;
                    acc_im_q <= val_im;
                    first_q  <= s2_last_q;
                    if (s2_last_q) begin
                        y_re_q    <= y_re_d;
                        y_im_q    <= y_im_d;
                        out_sat_q <= sat_re || sat_im;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_coarse_cfo_cmul_pipe.sv
// Self-checking bench: one per-beat instance and one accumulating instance, driven with
// directed and random beats under random backpressure, compared against a plain
// arithmetic model of the complex product, rounding and clipping.
module tb_coarse_cfo_cmul_pipe;
    localparam int DIN_W    = 16;
    localparam int DOUT_W   = 16;
    localparam int SHIFT    = 15;
    localparam int ACC_GROW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    coarse_cfo_cmul_pipe_if #(.DIN_W(DIN_W), .DOUT_W(DOUT_W)) if0 ();
    coarse_cfo_cmul_pipe_if #(.DIN_W(DIN_W), .DOUT_W(DOUT_W)) if1 ();

    coarse_cfo_cmul_pipe #(
        .DIN_W(DIN_W), .DOUT_W(DOUT_W), .SHIFT(SHIFT), .ACCUM(0), .ACC_GROW(ACC_GROW)
    ) u_dut0 (
        .ap_clk(clk),
        .ap_rst(rst),
        .bus   (if0)
    );

    coarse_cfo_cmul_pipe #(
        .DIN_W(DIN_W), .DOUT_W(DOUT_W), .SHIFT(SHIFT), .ACCUM(1), .ACC_GROW(ACC_GROW)
    ) u_dut1 (
        .ap_clk(clk),
        .ap_rst(rst),
        .bus   (if1)
    );

    typedef struct {
        longint y_re;
        longint y_im;
        bit     sat;
        int     cyc;
        int     stalls;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     stall_cnt[2];
    bit     hold_prev[2];
    longint held_re[2];
    longint held_im[2];
    bit     held_sat[2];
    bit     rst_seen[2];
    longint acc_re_m = 0;
    longint acc_im_m = 0;
    int     stall_left[2];
    bit     rand_bp[2];

    task automatic check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic void cmul(input longint ar, input longint ai, input longint br,
                                 input longint bi, input bit cj,
                                 output longint re, output longint im);
        if (cj) begin
            re = ar * br + ai * bi;
            im = ai * br - ar * bi;
        end else begin
            re = ar * br - ai * bi;
            im = ar * bi + ai * br;
        end
    endfunction

    function automatic void conv(input longint v, output longint y, output bit s);
        longint r;
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (DOUT_W - 1)) - 1;
        lo = -(64'sd1 <<< (DOUT_W - 1));
        r = v;
        if (SHIFT > 0) r = (v + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
        s = 1'b0;
        y = r;
        if (r > hi) begin
            y = hi;
            s = 1'b1;
        end else if (r < lo) begin
            y = lo;
            s = 1'b1;
        end
    endfunction

    function automatic exp_t make_exp(input longint re, input longint im);
        exp_t e;
        bit   s_re;
        bit   s_im;
        conv(re, e.y_re, s_re);
        conv(im, e.y_im, s_im);
        e.sat    = s_re | s_im;
        e.cyc    = 0;
        e.stalls = 0;
        return e;
    endfunction

    // Pin the model against hand-computed values for a sum (re, im).
    task automatic pin(input string name, input longint re, input longint im,
                       input longint er, input longint ei, input bit es);
        exp_t e;
        e = make_exp(re, im);
        check({name, "_model_re"}, e.y_re, er);
        check({name, "_model_im"}, e.y_im, ei);
        check({name, "_model_sat"}, e.sat, es);
    endtask

    task automatic pin_mul(input string name, input int ar, input int ai, input int br,
                           input int bi, input bit cj,
                           input longint er, input longint ei, input bit es);
        longint re;
        longint im;
        cmul(ar, ai, br, bi, cj, re, im);
        pin(name, re, im, er, ei, es);
    endtask

    // Per-cycle observer for one instance: scoreboard, latency, hold and handshake checks.
    task automatic mon(input int sel, input bit iv, input bit ir, input bit last, input bit cj,
                       input longint ar, input longint ai, input longint br, input longint bi,
                       input bit ov, input bit ordy, input longint yr, input longint yi,
                       input bit sat);
        exp_t   e;
        int     qn;
        longint pre;
        longint pim;
        string  tag;
        tag = $sformatf("dut%0d", sel);
        if (rst) begin
            if (sel == 0) q0.delete();
            else q1.delete();
            if (sel == 1) begin
                acc_re_m = 0;
                acc_im_m = 0;
            end
            hold_prev[sel] = 1'b0;
            rst_seen[sel]  = 1'b1;
            return;
        end
        if (rst_seen[sel]) begin
            check({tag, "_rst_out_valid"}, ov, 0);
            check({tag, "_rst_y_re"}, yr, 0);
            check({tag, "_rst_y_im"}, yi, 0);
            check({tag, "_rst_out_sat"}, sat, 0);
            rst_seen[sel] = 1'b0;
        end
        check({tag, "_in_ready"}, ir, !ov || ordy);
        if (ov) begin
            if (hold_prev[sel]) begin
                check({tag, "_hold_y_re"}, yr, held_re[sel]);
                check({tag, "_hold_y_im"}, yi, held_im[sel]);
                check({tag, "_hold_sat"}, sat, held_sat[sel]);
            end else begin
                qn = (sel == 0) ? q0.size() : q1.size();
                if (qn == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL %s_unexpected_output: got y=(%0d,%0d), expected no output",
                             tag, yr, yi);
                end else begin
                    e = (sel == 0) ? q0[0] : q1[0];
                    check({tag, "_y_re"}, yr, e.y_re);
                    check({tag, "_y_im"}, yi, e.y_im);
                    check({tag, "_out_sat"}, sat, e.sat);
                    check({tag, "_latency"}, cyc - e.cyc, 3 + stall_cnt[sel] - e.stalls);
                end
            end
            if (ordy) begin
                if (sel == 0 && q0.size() > 0) void'(q0.pop_front());
                if (sel == 1 && q1.size() > 0) void'(q1.pop_front());
            end else begin
                stall_cnt[sel]++;
            end
            hold_prev[sel] = !ordy;
            held_re[sel]   = yr;
            held_im[sel]   = yi;
            held_sat[sel]  = sat;
        end else begin
            hold_prev[sel] = 1'b0;
        end
        if (iv && ir) begin
            cmul(ar, ai, br, bi, cj, pre, pim);
            if (sel == 0) begin
                e        = make_exp(pre, pim);
                e.cyc    = cyc;
                e.stalls = stall_cnt[sel];
                q0.push_back(e);
            end else begin
                acc_re_m += pre;
                acc_im_m += pim;
                if (last) begin
                    e        = make_exp(acc_re_m, acc_im_m);
                    e.cyc    = cyc;
                    e.stalls = stall_cnt[sel];
                    q1.push_back(e);
                    acc_re_m = 0;
                    acc_im_m = 0;
                end
            end
        end
    endtask

    // Compare process, sampling mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            mon(0, if0.in_valid, if0.in_ready, if0.in_last, if0.conj_b, if0.a_re, if0.a_im,
                if0.b_re, if0.b_im, if0.out_valid, if0.out_ready, if0.y_re, if0.y_im,
                if0.out_sat);
            mon(1, if1.in_valid, if1.in_ready, if1.in_last, if1.conj_b, if1.a_re, if1.a_im,
                if1.b_re, if1.b_im, if1.out_valid, if1.out_ready, if1.y_re, if1.y_im,
                if1.out_sat);
        end
    end

    // Downstream readiness: forced stalls, random backpressure or always ready
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_left[0] > 0) begin
                if0.out_ready = 1'b0;
                stall_left[0]--;
            end else begin
                if0.out_ready = rand_bp[0] ? ($urandom_range(3) != 0) : 1'b1;
            end
            if (stall_left[1] > 0) begin
                if1.out_ready = 1'b0;
                stall_left[1]--;
            end else begin
                if1.out_ready = rand_bp[1] ? ($urandom_range(3) != 0) : 1'b1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one beat and hold it until the instance accepts it.
    task automatic send(input int sel, input int ar, input int ai, input int br, input int bi,
                        input bit cj, input bit last);
        int n;
        bit ok;
        if (sel == 0) begin
            if0.a_re = DIN_W'(ar);
            if0.a_im = DIN_W'(ai);
            if0.b_re = DIN_W'(br);
            if0.b_im = DIN_W'(bi);
            if0.conj_b = cj;
            if0.in_last = last;
            if0.in_valid = 1'b1;
        end else begin
            if1.a_re = DIN_W'(ar);
            if1.a_im = DIN_W'(ai);
            if1.b_re = DIN_W'(br);
            if1.b_im = DIN_W'(bi);
            if1.conj_b = cj;
            if1.in_last = last;
            if1.in_valid = 1'b1;
        end
        n  = 0;
        ok = 1'b0;
        while (!ok) begin
            @(negedge clk);
            ok = (sel == 0) ? if0.in_ready : if1.in_ready;
            @(posedge clk);
            #1;
            n++;
            if (n > 1000) begin
                $display("FAIL send_timeout dut%0d: in_ready stayed 0 for %0d cycles", sel, n);
                $fatal(1, "input handshake stuck");
            end
        end
        if (sel == 0) if0.in_valid = 1'b0;
        else if1.in_valid = 1'b0;
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    initial begin
        int len;
        int n;
        if0.in_valid = 1'b0;
        if0.a_re = '0; if0.a_im = '0; if0.b_re = '0; if0.b_im = '0;
        if0.conj_b = 1'b0; if0.in_last = 1'b0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0;
        if1.a_re = '0; if1.a_im = '0; if1.b_re = '0; if1.b_im = '0;
        if1.conj_b = 1'b0; if1.in_last = 1'b0; if1.out_ready = 1'b1;
        stall_left[0] = 0;
        stall_left[1] = 0;
        rand_bp[0] = 1'b0;
        rand_bp[1] = 1'b0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);

        // Directed multiplies on the per-beat instance
        pin_mul("basic", 16384, 0, 16384, 0, 1'b0, 8192, 0, 1'b0);
        send(0, 16384, 0, 16384, 0, 1'b0, 1'b0);
        pin_mul("conj0", 0, 16384, 0, 16384, 1'b0, -8192, 0, 1'b0);
        pin_mul("conj1", 0, 16384, 0, 16384, 1'b1, 8192, 0, 1'b0);
        send(0, 0, 16384, 0, 16384, 1'b0, 1'b0);
        send(0, 0, 16384, 0, 16384, 1'b1, 1'b0);
        pin_mul("round_up", 1, 0, 16384, 0, 1'b0, 1, 0, 1'b0);
        pin_mul("round_neg", -1, 0, 16384, 0, 1'b0, 0, 0, 1'b0);
        pin_mul("sat_pos", -32768, 0, -32768, 0, 1'b0, 32767, 0, 1'b1);
        send(0, 1, 0, 16384, 0, 1'b0, 1'b0);
        send(0, -1, 0, 16384, 0, 1'b0, 1'b0);
        send(0, -32768, 0, -32768, 0, 1'b0, 1'b0);
        send(0, -32768, -32768, -32768, 32767, 1'b1, 1'b0);
        step(6);

        // Ten random beats with a five-cycle downstream stall mid-stream
        for (int i = 0; i < 10; i++) begin
            if (i == 4) stall_left[0] = 5;
            send(0, rnd_s(), rnd_s(), rnd_s(), rnd_s(), 1'($urandom_range(1)), 1'b0);
        end
        step(12);

        // Long random stream with bubbles and random backpressure
        rand_bp[0] = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send(0, rnd_s(), rnd_s(), rnd_s(), rnd_s(), 1'($urandom_range(1)),
                 1'($urandom_range(1)));
            if ($urandom_range(3) == 0) step(1);
        end
        rand_bp[0] = 1'b0;
        step(10);

        // Accumulating instance: three-beat window then a one-beat window
        pin("acc3", 64'sd805306368, 0, 24576, 0, 1'b0);
        send(1, 16384, 0, 16384, 0, 1'b0, 1'b0);
        send(1, 16384, 0, 16384, 0, 1'b0, 1'b0);
        send(1, 16384, 0, 16384, 0, 1'b0, 1'b1);
        send(1, 16384, 0, 16384, 0, 1'b0, 1'b1);
        step(6);

        // Reset with two beats of a window already accepted
        send(1, 12345, -2222, 30000, 777, 1'b0, 1'b0);
        send(1, -31000, 4000, 29000, -15000, 1'b1, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        pin_mul("post_rst", 1000, -2000, 3000, 500, 1'b0, 122, -168, 1'b0);
        send(1, 1000, -2000, 3000, 500, 1'b0, 1'b1);
        step(6);

        // Random back-to-back windows under random backpressure
        rand_bp[1] = 1'b1;
        for (int w = 0; w < 40; w++) begin
            len = int'($urandom_range(6, 1));
            for (int j = 0; j < len; j++) begin
                send(1, rnd_s(), rnd_s(), rnd_s(), rnd_s(), 1'($urandom_range(1)),
                     (j == len - 1));
                if ($urandom_range(4) == 0) step(1);
            end
        end
        rand_bp[1] = 1'b0;

        // Drain, bounded
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            step(1);
            n++;
        end
        step(2);
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d results outstanding, expected 0/0",
                     q0.size(), q1.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
